// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: store drain > load > fetch, with a starvation guard for fetch.
// One outstanding bus transaction; responses for withdrawn requests are dropped.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_fetch_addr,
  input  logic        mem_fetch_addr_en,
  output logic [31:0] mem_inst_in,
  output logic        mem_inst_valid,
  output logic        mem_inst_access_fault,
  input  logic [31:0] mem_data_addr,
  input  logic        mem_data_addr_valid,
  input  logic [1:0]  mem_data_size,
  output logic [31:0] mem_data_in,
  output logic        mem_data_valid,
  output logic        mem_data_access_fault,
  input  logic        datafifo_empty,
  input  logic [31:0] datafifo_addr,
  input  logic [31:0] datafifo_val,
  input  logic [1:0]  datafifo_size,
  output logic        datafifo_pop,
  output logic        store_fault,
  output logic [31:0] store_fault_addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [1:0]  bus_size,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  input  logic        bus_fault
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  typedef enum logic [1:0] {OwnFetch, OwnLoad, OwnStore} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [1:0]      bus_size_q, bus_size_d;
  logic            pop_q, pop_d;
  logic [31:0]     inst_in_q, inst_in_d, data_in_q, data_in_d;
  logic            inst_valid_q, inst_valid_d, inst_fault_q, inst_fault_d;
  logic            data_valid_q, data_valid_d, data_fault_q, data_fault_d;
  logic            store_fault_q, store_fault_d;
  logic [31:0]     store_fault_addr_q, store_fault_addr_d;

  logic fetch_forced, grant_fetch, grant_load, grant_store;
  logic fetch_hit, load_hit;

  always_comb begin
    fetch_forced = mem_fetch_addr_en && (starve_cnt_q == CntMax);
    grant_store  = !fetch_forced && !datafifo_empty;
    grant_load   = !fetch_forced && datafifo_empty && mem_data_addr_valid;
    grant_fetch  = fetch_forced ||
                   (mem_fetch_addr_en && datafifo_empty && !mem_data_addr_valid);
    // A response is only delivered if the requester still asks for the same address.
    fetch_hit    = mem_fetch_addr_en && (mem_fetch_addr == bus_addr_q);
    load_hit     = mem_data_addr_valid && (mem_data_addr == bus_addr_q);

    state_d            = state_q;
    owner_d            = owner_q;
    starve_cnt_d       = starve_cnt_q;
    bus_req_d          = bus_req_q;
    bus_we_d           = bus_we_q;
    bus_addr_d         = bus_addr_q;
    bus_wdata_d        = bus_wdata_q;
    bus_size_d         = bus_size_q;
    pop_d              = 1'b0;
    inst_in_d          = inst_in_q;
    inst_valid_d       = 1'b0;
    inst_fault_d       = 1'b0;
    data_in_d          = data_in_q;
    data_valid_d       = 1'b0;
    data_fault_d       = 1'b0;
    store_fault_d      = 1'b0;
    store_fault_addr_d = store_fault_addr_q;

    if (!mem_fetch_addr_en) starve_cnt_d = '0;

    unique case (state_q)
      StIdle: begin
        if (grant_store) begin
          owner_d     = OwnStore;
          bus_we_d    = 1'b1;
          bus_addr_d  = datafifo_addr;
          bus_wdata_d = datafifo_val;
          bus_size_d  = datafifo_size;
          pop_d       = 1'b1;
        end else if (grant_load) begin
          owner_d     = OwnLoad;
          bus_we_d    = 1'b0;
          bus_addr_d  = mem_data_addr;
          bus_wdata_d = '0;
          bus_size_d  = mem_data_size;
        end else if (grant_fetch) begin
          owner_d     = OwnFetch;
          bus_we_d    = 1'b0;
          bus_addr_d  = mem_fetch_addr;
          bus_wdata_d = '0;
          bus_size_d  = 2'd2;
        end
        if (grant_store || grant_load || grant_fetch) begin
          state_d   = StReq;
          bus_req_d = 1'b1;
        end
        if ((grant_store || grant_load) && mem_fetch_addr_en && (starve_cnt_q != CntMax)) begin
          starve_cnt_d = starve_cnt_q + CntW'(1);
        end
        if (grant_fetch) starve_cnt_d = '0;
      end
      StReq: begin
        if (bus_ready) begin
          bus_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (bus_rvalid) begin
          state_d = StIdle;
          unique case (owner_q)
            OwnFetch: begin
              if (fetch_hit) begin
                inst_valid_d = 1'b1;
                inst_in_d    = bus_rdata;
                inst_fault_d = bus_fault;
              end
            end
            OwnLoad: begin
              if (load_hit) begin
                data_valid_d = 1'b1;
                data_in_d    = bus_rdata;
                data_fault_d = bus_fault;
              end
            end
            OwnStore: begin
              if (bus_fault) begin
                store_fault_d      = 1'b1;
                store_fault_addr_d = bus_addr_q;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= StIdle;
      owner_q            <= OwnFetch;
      starve_cnt_q       <= '0;
      bus_req_q          <= 1'b0;
      bus_we_q           <= 1'b0;
      bus_addr_q         <= '0;
      bus_wdata_q        <= '0;
      bus_size_q         <= '0;
      pop_q              <= 1'b0;
      inst_in_q          <= '0;
      inst_valid_q       <= 1'b0;
      inst_fault_q       <= 1'b0;
      data_in_q          <= '0;
      data_valid_q       <= 1'b0;
      data_fault_q       <= 1'b0;
      store_fault_q      <= 1'b0;
      store_fault_addr_q <= '0;
    end else begin
      state_q            <= state_d;
      owner_q            <= owner_d;
      starve_cnt_q       <= starve_cnt_d;
      bus_req_q          <= bus_req_d;
      bus_we_q           <= bus_we_d;
      bus_addr_q         <= bus_addr_d;
      bus_wdata_q        <= bus_wdata_d;
      bus_size_q         <= bus_size_d;
      pop_q              <= pop_d;
      inst_in_q          <= inst_in_d;
      inst_valid_q       <= inst_valid_d;
      inst_fault_q       <= inst_fault_d;
      data_in_q          <= data_in_d;
      data_valid_q       <= data_valid_d;
      data_fault_q       <= data_fault_d;
      store_fault_q      <= store_fault_d;
      store_fault_addr_q <= store_fault_addr_d;
    end
  end

  assign mem_inst_in           = inst_in_q;
  assign mem_inst_valid        = inst_valid_q;
  assign mem_inst_access_fault = inst_fault_q;
  assign mem_data_in           = data_in_q;
  assign mem_data_valid        = data_valid_q;
  assign mem_data_access_fault = data_fault_q;
  assign datafifo_pop          = pop_q;
  assign store_fault           = store_fault_q;
  assign store_fault_addr      = store_fault_addr_q;
  assign bus_req               = bus_req_q;
  assign bus_we                = bus_we_q;
  assign bus_addr              = bus_addr_q;
  assign bus_wdata             = bus_wdata_q;
  assign bus_size              = bus_size_q;

endmodule
